axi_write_burst_tracker: RTL and testbench
==========================================

# axi_write_burst_tracker

Parametrised AXI write-path slave-side tracker, the next generation of the per-channel AW/W/B protocol FSMs. It accepts write addresses into a queue of up to MAX_OUT outstanding bursts and steps the W channel through each burst. Per beat it generates wlast and the beat address for FIXED, INCR and WRAP bursts. It returns one B response per burst through a response queue. The block sits between the AXI master interface and the memory-side write logic in the protocol verification environment.

## Interface
- AW, default 32: address width.
- DW, default 64: data width; power of 2, 8..1024.
- MAX_OUT, default 4: maximum outstanding write bursts; power of 2, ≥2.
- axi_aclk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- awvalid_in  in  1  write address valid.
- awaddr_in  in  AW  burst start address.
- awlen_in  in  8  beats minus 1.
- awsize_in  in  3  log2 bytes per beat.
- awburst_in  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_awready  out  1  address accepted this cycle when awvalid_in is also high.
- wvalid_in  in  1  write data valid.
- wdata_in  in  DW  write data; passed through, not stored.
- wstrb_in  in  DW/8  byte strobes; passed through.
- wlast_in  in  1  master's last-beat flag; checked against axi_wlast.
- axi_wready  out  1  beat accepted when wvalid_in is also high.
- axi_wlast  out  1  current beat is the final beat of the active burst.
- axi_wbeat_addr  out  AW  address of the current beat.
- bready_in  in  1  master ready for response.
- axi_bvalid  out  1  response available.
- axi_bresp  out  2  00 OKAY, 10 SLVERR.
- outstanding  out  $clog2(MAX_OUT)+1  count of bursts with AW accepted and B not yet handshaken.

## Operation
- axi_awready = !rst && outstanding < MAX_OUT. AW handshake pushes {addr,len,size,burst} into the AW queue (depth MAX_OUT). Because the queue is bounded by the outstanding count, it cannot overflow.
- The outstanding count increments on an AW handshake and decrements on a B handshake. When both occur in the same cycle, the count is unchanged.
- The W FSM has two states, W_IDLE and W_BURST.
  - W_IDLE: when the AW queue is non-empty, pop the head. Load beat_cnt=len, cur_addr=addr, err=(burst==11 or size>log2(DW/8) or (burst==WRAP and len∉{1,3,7,15})). Go to W_BURST.
  - W_BURST: axi_wready=1. On a W handshake:
    - Set err |= (wlast_in != axi_wlast).
    - Advance cur_addr.
    - Decrement beat_cnt.
    - On the last beat (beat_cnt==0), push SLVERR if err else OKAY into the B queue and return to W_IDLE.
- axi_wready=0 in W_IDLE, so W beats presented before their AW are held off.
- axi_wlast = (state==W_BURST && beat_cnt==0). axi_wbeat_addr = cur_addr.
- Address step, with incr = 1<<size:
  - FIXED: cur_addr is unchanged.
  - INCR: cur_addr += incr, modulo 2^AW. There is no 4 KB check.
  - WRAP: bound = (len+1)<<size; cur_addr = (cur_addr & ~(bound-1)) | ((cur_addr+incr) & (bound-1)).
- B queue (depth MAX_OUT): axi_bvalid = non-empty; axi_bresp = head. Pop on axi_bvalid && bready_in. Responses are returned strictly in AW order.
- An erroneous burst still consumes all len+1 beats; only its response changes.

## Timing
- Reset values: axi_awready=0, axi_wready=0, axi_wlast=0, axi_wbeat_addr=0, axi_bvalid=0, axi_bresp=00, outstanding=0. Both queues are empty and the W FSM is in W_IDLE. axi_awready becomes 1 the first cycle after rst deasserts.
- Reset mid-operation: all queues, counters and the FSM clear on the next edge, and in-flight bursts are discarded without responses.
- AW handshake in cycle N makes the queue head visible in N+1, enters W_BURST in N+2, and raises axi_wready in N+2.
- Back-to-back bursts: after the last beat the FSM spends one W_IDLE cycle, so the first beat of the next burst is accepted no earlier than 2 cycles after the previous last beat.
- Last-beat handshake in cycle M makes axi_bvalid=1 in M+1 if the B queue was empty.
- An AW handshake can occur in the same cycle as a W handshake and a B handshake.

## Test plan
- Single INCR burst: awaddr=0x100, len=3, size=3, DW=64, then 4 beats with wlast_in on beat 4 -> wbeat_addr 0x100, 0x108, 0x110, 0x118; axi_wlast high on beat 4 only; bresp=00 one cycle after beat 4; outstanding returns to 0.
- WRAP burst: addr=0x38, len=3, size=3 -> wbeat_addr 0x38, 0x20, 0x28, 0x30; bresp=00. Repeat with len=2 -> bresp=10 after 3 beats.
- FIXED burst: addr=0x40, len=2 -> all 3 beats at 0x40. Then wlast_in asserted on beat 2 -> bresp=10.
- Outstanding limit with MAX_OUT=4 and bready_in=0: 5 AW requests -> axi_awready drops after the 4th and outstanding=4. Pulsing bready_in one cycle -> exactly 1 more AW accepted. Responses come out in AW order.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst -> the next cycle shows all outputs at reset values and no B response appears. A new burst after reset completes normally.

Source files
------------

// File: rtl/axi_write_burst_tracker.sv
// AXI write-path slave-side tracker.
// Queues accepted write addresses, walks the W channel through each burst
// (generating wlast and per-beat addresses for FIXED/INCR/WRAP), and returns
// one B response per burst in AW order.
module axi_write_burst_tracker #(
   parameter int AW      = 32,
   parameter int DW      = 64,
   parameter int MAX_OUT = 4
) (
   input  logic                         axi_aclk,
   input  logic                         rst,
   input  logic                         awvalid_in,
   input  logic [AW-1:0]                awaddr_in,
   input  logic [7:0]                   awlen_in,
   input  logic [2:0]                   awsize_in,
   input  logic [1:0]                   awburst_in,
   output logic                         axi_awready,
   input  logic                         wvalid_in,
   input  logic [DW-1:0]                wdata_in,
   input  logic [DW/8-1:0]              wstrb_in,
   input  logic                         wlast_in,
   output logic                         axi_wready,
   output logic                         axi_wlast,
   output logic [AW-1:0]                axi_wbeat_addr,
   input  logic                         bready_in,
   output logic                         axi_bvalid,
   output logic [1:0]                   axi_bresp,
   output logic [$clog2(MAX_OUT):0]     outstanding
);

   localparam int PW     = $clog2(MAX_OUT);
   localparam int CW     = PW + 1;
   localparam int SZ_MAX = $clog2(DW / 8);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE,
      W_BURST
   } w_state_t;

   w_state_t state, state_nxt;

   // AW queue
   logic [AW-1:0] aq_addr  [MAX_OUT];
   logic [7:0]    aq_len   [MAX_OUT];
   logic [2:0]    aq_size  [MAX_OUT];
   logic [1:0]    aq_burst [MAX_OUT];
   logic [PW-1:0] aq_wptr, aq_rptr;
   logic [CW-1:0] aq_cnt;

   // B queue
   logic [1:0]    bq_resp  [MAX_OUT];
   logic [PW-1:0] bq_wptr, bq_rptr;
   logic [CW-1:0] bq_cnt;

   // Active burst context
   logic [7:0]    beat_cnt;
   logic [AW-1:0] cur_addr;
   logic [7:0]    cur_len;
   logic [2:0]    cur_size;
   logic [1:0]    cur_burst;
   logic          err;

   logic          aw_hs, w_hs, last_hs, b_hs, aq_pop;
   logic          head_err, beat_mismatch;
   logic [1:0]    last_resp;
   logic [AW-1:0] incr, bound, wrap_mask, next_addr;

   // Data and strobes flow to the memory side directly; only the handshake matters here.
   logic unused_bits;
   assign unused_bits = ^{wdata_in, wstrb_in};

   assign axi_awready    = !rst && (outstanding < CW'(MAX_OUT));
   assign aw_hs          = awvalid_in && axi_awready;
   assign b_hs           = axi_bvalid && bready_in;
   assign axi_wlast      = (state == W_BURST) && (beat_cnt == 8'd0);
   assign axi_wbeat_addr = cur_addr;
   assign axi_bvalid     = (bq_cnt != '0);
   assign axi_bresp      = axi_bvalid ? bq_resp[bq_rptr] : RESP_OKAY;

   // W FSM state register
   always_ff @(posedge axi_aclk) begin
      if (rst) state <= W_IDLE;
      else     state <= state_nxt;
   end

   // W FSM next-state, queue pop and handshake decode
   always_comb begin
      state_nxt  = state;
      axi_wready = 1'b0;
      aq_pop     = 1'b0;
      w_hs       = 1'b0;
      last_hs    = 1'b0;
      case (state)
         W_IDLE: begin
            if (aq_cnt != '0) begin
               aq_pop    = 1'b1;
               state_nxt = W_BURST;
            end
         end
         W_BURST: begin
            axi_wready = 1'b1;
            w_hs       = wvalid_in;
            last_hs    = wvalid_in && (beat_cnt == 8'd0);
            if (last_hs) state_nxt = W_IDLE;
         end
         default: state_nxt = W_IDLE;
      endcase
   end

   // Burst legality of the queue head and the beat address step
   always_comb begin
      head_err = (aq_burst[aq_rptr] == BURST_RSVD) ||
                 (aq_size[aq_rptr] > 3'(SZ_MAX)) ||
                 ((aq_burst[aq_rptr] == BURST_WRAP) &&
                  !(aq_len[aq_rptr] inside {8'd1, 8'd3, 8'd7, 8'd15}));
      incr      = AW'(1) << cur_size;
      bound     = AW'({1'b0, cur_len} + 9'd1) << cur_size;
      wrap_mask = bound - AW'(1);
      case (cur_burst)
         BURST_FIXED: next_addr = cur_addr;
         BURST_INCR:  next_addr = cur_addr + incr;
         BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + incr) & wrap_mask);
         default:     next_addr = cur_addr + incr;
      endcase
      beat_mismatch = (wlast_in != axi_wlast);
      last_resp     = (err || beat_mismatch) ? RESP_SLVERR : RESP_OKAY;
   end

   // AW queue storage
   always_ff @(posedge axi_aclk) begin
      if (aw_hs) begin
         aq_addr[aq_wptr]  <= awaddr_in;
         aq_len[aq_wptr]   <= awlen_in;
         aq_size[aq_wptr]  <= awsize_in;
         aq_burst[aq_wptr] <= awburst_in;
      end
   end

   // AW queue pointers and occupancy
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         aq_wptr <= '0;
         aq_rptr <= '0;
         aq_cnt  <= '0;
      end else begin
         if (aw_hs)  aq_wptr <= aq_wptr + PW'(1);
         if (aq_pop) aq_rptr <= aq_rptr + PW'(1);
         aq_cnt <= aq_cnt + CW'(aw_hs) - CW'(aq_pop);
      end
   end

   // Active burst context: load on pop, step on each accepted beat
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         beat_cnt  <= '0;
         cur_addr  <= '0;
         cur_len   <= '0;
         cur_size  <= '0;
         cur_burst <= '0;
         err       <= 1'b0;
      end else if (aq_pop) begin
         beat_cnt  <= aq_len[aq_rptr];
         cur_addr  <= aq_addr[aq_rptr];
         cur_len   <= aq_len[aq_rptr];
         cur_size  <= aq_size[aq_rptr];
         cur_burst <= aq_burst[aq_rptr];
         err       <= head_err;
      end else if (w_hs) begin
         beat_cnt <= beat_cnt - 8'd1;
         cur_addr <= next_addr;
         err      <= err | beat_mismatch;
      end
   end

   // B queue storage; the last beat's own wlast mismatch is folded into its response
   always_ff @(posedge axi_aclk) begin
      if (last_hs) bq_resp[bq_wptr] <= last_resp;
   end

   // B queue pointers and occupancy
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         bq_wptr <= '0;
         bq_rptr <= '0;
         bq_cnt  <= '0;
      end else begin
         if (last_hs) bq_wptr <= bq_wptr + PW'(1);
         if (b_hs)    bq_rptr <= bq_rptr + PW'(1);
         bq_cnt <= bq_cnt + CW'(last_hs) - CW'(b_hs);
      end
   end

   // Outstanding bursts: AW accepted, B not yet handshaken
   always_ff @(posedge axi_aclk) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({aw_hs, b_hs})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_write_burst_tracker.sv
// Scoreboard bench for axi_write_burst_tracker: stimulus pushes expected
// beats/responses, a negedge monitor pops and compares on each handshake.
module tb_axi_write_burst_tracker;

   localparam int AW      = 32;
   localparam int DW      = 64;
   localparam int MAX_OUT = 4;
   localparam int OW      = $clog2(MAX_OUT) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            awvalid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awready;
   logic            wvalid;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast_in;
   logic            wready;
   logic            wlast;
   logic [AW-1:0]   wbeat_addr;
   logic            bready;
   logic            bvalid;
   logic [1:0]      bresp;
   logic [OW-1:0]   outstanding;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          last;
   } wexp_t;

   wexp_t      w_exp[$];
   logic [1:0] b_exp[$];
   wexp_t      we;
   logic [1:0] be;

   always #5 clk = ~clk;

   axi_write_burst_tracker #(
      .AW      (AW),
      .DW      (DW),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .axi_aclk       (clk),
      .rst            (rst),
      .awvalid_in     (awvalid),
      .awaddr_in      (awaddr),
      .awlen_in       (awlen),
      .awsize_in      (awsize),
      .awburst_in     (awburst),
      .axi_awready    (awready),
      .wvalid_in      (wvalid),
      .wdata_in       (wdata),
      .wstrb_in       (wstrb),
      .wlast_in       (wlast_in),
      .axi_wready     (wready),
      .axi_wlast      (wlast),
      .axi_wbeat_addr (wbeat_addr),
      .bready_in      (bready),
      .axi_bvalid     (bvalid),
      .axi_bresp      (bresp),
      .outstanding    (outstanding)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every W and B handshake against the scoreboard queues
   always @(negedge clk) begin
      if (!rst && wvalid && wready) begin
         if (w_exp.size() == 0) begin
            timeout_fail("w_unexpected_beat");
         end else begin
            we = w_exp.pop_front();
            chk("w_beat_addr", wbeat_addr, we.addr);
            chk("w_last", wlast, we.last);
         end
      end
      if (!rst && bvalid && bready) begin
         if (b_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected actual=%0h required=none", bresp);
         end else begin
            be = b_exp.pop_front();
            chk("b_resp", bresp, be);
         end
      end
   end

   task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                        input logic [1:0] b, input logic [1:0] resp);
      int t = 0;
      b_exp.push_back(resp);
      awvalid = 1'b1;
      awaddr  = a;
      awlen   = l;
      awsize  = s;
      awburst = b;
      forever begin
         @(negedge clk);
         if (awready) break;
         t++;
         if (t > 50) begin
            timeout_fail("aw_handshake");
            break;
         end
      end
      @(posedge clk);
      #1;
      awvalid = 1'b0;
   endtask

   task automatic do_beat(input logic [AW-1:0] a, input logic last_exp, input logic wl);
      int t = 0;
      w_exp.push_back({a, last_exp});
      wvalid   = 1'b1;
      wlast_in = wl;
      wdata    = {$urandom, $urandom};
      wstrb    = '1;
      forever begin
         @(negedge clk);
         if (wready) break;
         t++;
         if (t > 50) begin
            timeout_fail("w_handshake");
            break;
         end
      end
      @(posedge clk);
      #1;
      wvalid   = 1'b0;
      wlast_in = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((b_exp.size() != 0 || w_exp.size() != 0) && t < 200) begin
         cycle();
         t++;
      end
      if (t >= 200) timeout_fail("drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      awvalid  = 1'b0;
      awaddr   = '0;
      awlen    = '0;
      awsize   = '0;
      awburst  = '0;
      wvalid   = 1'b0;
      wdata    = '0;
      wstrb    = '0;
      wlast_in = 1'b0;
      bready   = 1'b1;
      repeat (3) cycle();

      // Reset values
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_wlast", wlast, 0);
      chk("rst_wbeat_addr", wbeat_addr, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_outstanding", outstanding, 0);
      rst = 1'b0;
      #1;
      chk("awready_after_rst", awready, 1);
      cycle();

      // Single INCR burst with AW->W latency and B latency
      do_aw(32'h100, 8'd3, 3'd3, 2'b01, 2'b00);
      chk("wready_n1", wready, 0);
      cycle();
      chk("wready_n2", wready, 1);
      chk("outstanding_one", outstanding, 1);
      do_beat(32'h100, 1'b0, 1'b0);
      do_beat(32'h108, 1'b0, 1'b0);
      do_beat(32'h110, 1'b0, 1'b0);
      do_beat(32'h118, 1'b1, 1'b1);
      chk("bvalid_m1", bvalid, 1);
      chk("bresp_m1", bresp, 0);
      cycle();
      chk("outstanding_zero", outstanding, 0);
      chk("bvalid_popped", bvalid, 0);
      wait_drain();

      // WRAP legal, then WRAP with illegal length
      do_aw(32'h38, 8'd3, 3'd3, 2'b10, 2'b00);
      do_beat(32'h38, 1'b0, 1'b0);
      do_beat(32'h20, 1'b0, 1'b0);
      do_beat(32'h28, 1'b0, 1'b0);
      do_beat(32'h30, 1'b1, 1'b1);
      wait_drain();
      do_aw(32'h38, 8'd2, 3'd3, 2'b10, 2'b10);
      do_beat(32'h38, 1'b0, 1'b0);
      do_beat(32'h28, 1'b0, 1'b0);
      do_beat(32'h38, 1'b1, 1'b1);
      wait_drain();

      // FIXED, then FIXED with early wlast_in
      do_aw(32'h40, 8'd2, 3'd3, 2'b00, 2'b00);
      do_beat(32'h40, 1'b0, 1'b0);
      do_beat(32'h40, 1'b0, 1'b0);
      do_beat(32'h40, 1'b1, 1'b1);
      wait_drain();
      do_aw(32'h40, 8'd2, 3'd3, 2'b00, 2'b10);
      do_beat(32'h40, 1'b0, 1'b0);
      do_beat(32'h40, 1'b0, 1'b1);
      do_beat(32'h40, 1'b1, 1'b0);
      wait_drain();

      // INCR address wraps modulo 2^AW
      do_aw(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 2'b00);
      do_beat(32'hFFFF_FFF8, 1'b0, 1'b0);
      do_beat(32'h0000_0000, 1'b1, 1'b1);
      wait_drain();

      // Outstanding limit with responses held back
      bready = 1'b0;
      do_aw(32'h1000, 8'd0, 3'd3, 2'b01, 2'b00);
      do_aw(32'h2000, 8'd0, 3'd3, 2'b11, 2'b10);
      do_aw(32'h3000, 8'd0, 3'd4, 2'b01, 2'b10);
      do_aw(32'h4000, 8'd0, 3'd3, 2'b01, 2'b00);
      chk("limit_outstanding", outstanding, 4);
      chk("limit_awready", awready, 0);
      b_exp.push_back(2'b00);
      awvalid = 1'b1;
      awaddr  = 32'h5000;
      awlen   = 8'd0;
      awsize  = 3'd3;
      awburst = 2'b01;
      do_beat(32'h1000, 1'b1, 1'b1);
      do_beat(32'h2000, 1'b1, 1'b1);
      do_beat(32'h3000, 1'b1, 1'b1);
      do_beat(32'h4000, 1'b1, 1'b1);
      cycle();
      chk("limit_held_awready", awready, 0);
      chk("limit_held_outstanding", outstanding, 4);
      bready = 1'b1;
      cycle();
      bready = 1'b0;
      chk("limit_reopen_awready", awready, 1);
      chk("limit_reopen_outstanding", outstanding, 3);
      cycle();
      awvalid = 1'b0;
      chk("limit_refill_outstanding", outstanding, 4);
      chk("limit_refill_awready", awready, 0);
      do_beat(32'h5000, 1'b1, 1'b1);
      bready = 1'b1;
      wait_drain();
      cycle();
      chk("limit_final_outstanding", outstanding, 0);

      // Reset during beat 2 of a len=7 burst
      do_aw(32'h200, 8'd7, 3'd3, 2'b01, 2'b00);
      do_beat(32'h200, 1'b0, 1'b0);
      wvalid = 1'b1;
      rst    = 1'b1;
      cycle();
      chk("midrst_awready", awready, 0);
      chk("midrst_wready", wready, 0);
      chk("midrst_wlast", wlast, 0);
      chk("midrst_wbeat_addr", wbeat_addr, 0);
      chk("midrst_bvalid", bvalid, 0);
      chk("midrst_bresp", bresp, 0);
      chk("midrst_outstanding", outstanding, 0);
      wvalid = 1'b0;
      rst    = 1'b0;
      b_exp.delete();
      w_exp.delete();
      #1;
      chk("midrst_awready_release", awready, 1);
      repeat (6) cycle();
      chk("midrst_no_b", bvalid, 0);
      do_aw(32'h300, 8'd1, 3'd3, 2'b01, 2'b00);
      do_beat(32'h300, 1'b0, 1'b0);
      do_beat(32'h308, 1'b1, 1'b1);
      wait_drain();
      cycle();

      chk("end_w_queue_empty", w_exp.size(), 0);
      chk("end_b_queue_empty", b_exp.size(), 0);
      chk("end_outstanding", outstanding, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
